// File: rtl/prog_instr_mem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
// State encoding, default NOP word and index-width helper.
package prog_instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } ld_state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prog_instr_mem_if.sv
// Fetch and streaming-load bus of the instruction memory.
// master drives requests/stream, slave is the memory.
interface prog_instr_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);

  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic              fetch_fault;

  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [LEN_W-1:0]  load_len;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;
  logic              load_error;

  modport master (
    output fetch_en, fetch_addr,
    output load_start, load_base, load_len,
    output load_valid, load_data,
    input  instr_out, instr_valid, fetch_fault,
    input  load_ready, load_busy, load_done,
    input  load_error
  );

  modport slave (
    input  fetch_en, fetch_addr,
    input  load_start, load_base, load_len,
    input  load_valid, load_data,
    output instr_out, instr_valid, fetch_fault,
    output load_ready, load_busy, load_done,
    output load_error
  );

endinterface

// File: rtl/imem_loader_fsm.sv
// Loader sequencer: accepts a word stream and emits
// write-enable/index/data for the storage array.
module imem_loader_fsm
  import prog_instr_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 128,
  parameter int LEN_W  = $clog2(DEPTH + 1),
  parameter int IDX_W  = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              we,
  output logic [IDX_W-1:0]  widx,
  output logic [DATA_W-1:0] wdata
);

  localparam int SUM_W = ADDR_W + 1;

  ld_state_t         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [SUM_W-1:0]  sum;
  logic              in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // One extra bit keeps base+cnt from wrapping into range
  assign sum      = {1'b0, base_q} + SUM_W'(cnt_q);
  assign in_range = sum < SUM_W'(DEPTH);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = LOAD;
            base_d  = base;
            len_d   = len;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (valid) begin
          we    = in_range;
          err_d = err_q | ~in_range;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == LOAD);
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign error = err_q;
  assign widx  = sum[IDX_W-1:0];
  assign wdata = data;

endmodule

// File: rtl/prog_instr_mem.sv
// Loadable instruction memory with registered fetch,
// range/alignment checking and a streaming load port.
module prog_instr_mem
  import prog_instr_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 128,
  parameter int BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] NOP_WORD =
    DATA_W'(NOP_DEFAULT)
) (
  input logic clk,
  input logic reset,
  prog_instr_mem_if.slave bus
);

  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int IDX_W = idx_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

  logic              we;
  logic [IDX_W-1:0]  widx;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] fidx;
  logic              bad;

  imem_loader_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W),
    .IDX_W  (IDX_W)
  ) u_loader (
    .clk   (clk),
    .reset (reset),
    .start (bus.load_start),
    .base  (bus.load_base),
    .len   (bus.load_len),
    .valid (bus.load_valid),
    .data  (bus.load_data),
    .ready (bus.load_ready),
    .busy  (bus.load_busy),
    .done  (bus.load_done),
    .error (bus.load_error),
    .we    (we),
    .widx  (widx),
    .wdata (wdata)
  );

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  always_comb begin
    fidx = (BYTE_ADDR != 0) ? (bus.fetch_addr >> 2)
                            : bus.fetch_addr;
    bad  = fidx >= ADDR_W'(DEPTH);
    if (BYTE_ADDR != 0 && bus.fetch_addr[1:0] != 2'b00) begin
      bad = 1'b1;
    end
  end

  // Fetches are squashed for the whole load, DONE included
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.instr_out   <= NOP_WORD;
      bus.instr_valid <= 1'b0;
      bus.fetch_fault <= 1'b0;
    end else if (bus.load_busy) begin
      bus.instr_out   <= NOP_WORD;
      bus.instr_valid <= 1'b0;
      bus.fetch_fault <= 1'b0;
    end else if (bus.fetch_en) begin
      bus.instr_valid <= 1'b1;
      bus.fetch_fault <= bad;
      bus.instr_out   <= bad ? NOP_WORD : mem[fidx[IDX_W-1:0]];
    end else begin
      bus.instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_instr_mem.sv
// Bench: word- and byte-addressed instances share one stimulus
// stream and are checked against a behavioural model.
module tb_prog_instr_mem;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        load_start = 1'b0;
  logic [31:0] load_base = '0;
  logic [7:0]  load_len = '0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;

  always #5 clk = ~clk;

  prog_instr_mem_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(8)) if0 ();
  prog_instr_mem_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(8)) if1 ();

  assign if0.fetch_en   = fetch_en;
  assign if0.fetch_addr = fetch_addr;
  assign if0.load_start = load_start;
  assign if0.load_base  = load_base;
  assign if0.load_len   = load_len;
  assign if0.load_valid = load_valid;
  assign if0.load_data  = load_data;
  assign if1.fetch_en   = fetch_en;
  assign if1.fetch_addr = fetch_addr;
  assign if1.load_start = load_start;
  assign if1.load_base  = load_base;
  assign if1.load_len   = load_len;
  assign if1.load_valid = load_valid;
  assign if1.load_data  = load_data;

  prog_instr_mem #(.DEPTH(DEPTH), .BYTE_ADDR(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  prog_instr_mem #(.DEPTH(DEPTH), .BYTE_ADDR(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Behavioural model: memory image plus words-remaining count
  logic [31:0] m_mem [DEPTH];
  longint      m_left = 0;
  longint      m_ptr = 0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] e_out0 = '0;
  logic [31:0] e_out1 = '0;
  bit          e_valid = 1'b0;
  bit          e_fault0 = 1'b0;
  bit          e_fault1 = 1'b0;

  function automatic logic [32:0] fetch_of(input bit bm,
                                           input logic [31:0] a);
    longint idx;
    idx = bm ? longint'(a) / 4 : longint'(a);
    if ((bm && (a % 4) != 0) || idx >= DEPTH) return {1'b1, 32'h0};
    return {1'b0, m_mem[idx]};
  endfunction

  initial begin
    logic [32:0] r0, r1;
    bit busy;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    forever begin
      @(posedge clk);
      busy = (m_left > 0) || m_done;
      if (reset) begin
        m_left = 0; m_done = 0; m_err = 0;
        e_out0 = '0; e_out1 = '0; e_valid = 0;
        e_fault0 = 0; e_fault1 = 0;
      end else begin
        if (busy) begin
          e_out0 = '0; e_out1 = '0; e_valid = 0;
          e_fault0 = 0; e_fault1 = 0;
        end else if (fetch_en) begin
          r0 = fetch_of(1'b0, fetch_addr);
          r1 = fetch_of(1'b1, fetch_addr);
          e_out0 = r0[31:0]; e_fault0 = r0[32];
          e_out1 = r1[31:0]; e_fault1 = r1[32];
          e_valid = 1;
        end else begin
          e_valid = 0;
        end
        if (m_done) begin
          m_done = 0;
        end else if (m_left > 0) begin
          if (load_valid) begin
            if (m_ptr < DEPTH) m_mem[m_ptr] = load_data;
            else m_err = 1;
            m_ptr++;
            m_left--;
            if (m_left == 0) m_done = 1;
          end
        end else if (load_start) begin
          if (load_len != 0) begin
            m_left = load_len; m_ptr = load_base; m_err = 0;
          end else begin
            m_done = 1;
          end
        end
      end
      #1;
      chk("out0", if0.instr_out, e_out0);
      chk("out1", if1.instr_out, e_out1);
      chk("valid0", 32'(if0.instr_valid), 32'(e_valid));
      chk("valid1", 32'(if1.instr_valid), 32'(e_valid));
      chk("fault0", 32'(if0.fetch_fault), 32'(e_fault0));
      chk("fault1", 32'(if1.fetch_fault), 32'(e_fault1));
      chk("ready0", 32'(if0.load_ready), 32'(m_left > 0));
      chk("busy0", 32'(if0.load_busy), 32'((m_left > 0) || m_done));
      chk("done0", 32'(if0.load_done), 32'(m_done));
      chk("done1", 32'(if1.load_done), 32'(m_done));
      chk("err0", 32'(if0.load_error), 32'(m_err));
      chk("err1", 32'(if1.load_error), 32'(m_err));
      if (if0.load_done) done_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_load(input logic [31:0] b, input logic [7:0] l);
    load_start = 1'b1; load_base = b; load_len = l;
    step();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    load_valid = 1'b1; load_data = w;
    step();
    load_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_en = 1'b1; fetch_addr = a;
    step();
  endtask

  initial begin
    step(); step();
    reset = 1'b0;

    fetch(0);
    chk("rst_out", if0.instr_out, 32'h0);
    chk("rst_valid", 32'(if0.instr_valid), 1);
    chk("rst_fault", 32'(if0.fetch_fault), 0);
    chk("rst_ready", 32'(if0.load_ready), 0);
    chk("rst_busy", 32'(if0.load_busy), 0);
    chk("rst_done", 32'(if0.load_done), 0);
    chk("rst_err", 32'(if0.load_error), 0);
    fetch_en = 1'b0;

    start_load(0, 3);
    send(32'h04100000);
    step();
    send(32'h04181002);
    chk("gap_busy", 32'(if0.load_busy), 1);
    send(32'h00800008);
    chk("l3_done", 32'(if0.load_done), 1);
    chk("l3_ready", 32'(if0.load_ready), 0);
    step();
    chk("l3_done_off", 32'(if0.load_done), 0);
    chk("l3_idle", 32'(if0.load_busy), 0);
    fetch(0);
    chk("f0", if0.instr_out, 32'h04100000);
    chk("b0", if1.instr_out, 32'h04100000);
    fetch(1);
    chk("f1", if0.instr_out, 32'h04181002);
    chk("b1_fault", 32'(if1.fetch_fault), 1);
    fetch(2);
    chk("f2", if0.instr_out, 32'h00800008);
    fetch(8);
    chk("b8", if1.instr_out, 32'h00800008);
    chk("b8_fault", 32'(if1.fetch_fault), 0);
    fetch(6);
    chk("b6_out", if1.instr_out, 32'h0);
    chk("b6_fault", 32'(if1.fetch_fault), 1);
    fetch_en = 1'b0;

    start_load(126, 4);
    send(32'hA0A0_0001);
    send(32'hA0A0_0002);
    send(32'hA0A0_0003);
    chk("ovf_busy", 32'(if0.load_busy), 1);
    send(32'hA0A0_0004);
    chk("ovf_done", 32'(if0.load_done), 1);
    chk("ovf_err", 32'(if0.load_error), 1);
    step();
    fetch(126);
    chk("f126", if0.instr_out, 32'hA0A0_0001);
    fetch(127);
    chk("f127", if0.instr_out, 32'hA0A0_0002);
    fetch(128);
    chk("f128_out", if0.instr_out, 32'h0);
    chk("f128_fault", 32'(if0.fetch_fault), 1);
    chk("f128_valid", 32'(if0.instr_valid), 1);
    fetch(0);
    chk("f0_kept", if0.instr_out, 32'h04100000);

    fetch_addr = 126;
    start_load(10, 3);
    chk("pre_out", if0.instr_out, 32'hA0A0_0001);
    fetch_addr = 0;
    send(32'hB000_0000);
    chk("ld_fetch_valid", 32'(if0.instr_valid), 0);
    chk("ld_fetch_out", if0.instr_out, 32'h0);
    chk("ld_err_clr", 32'(if0.load_error), 0);
    load_start = 1'b1; load_base = 50; load_len = 1;
    send(32'hB000_0001);
    load_start = 1'b0;
    chk("restart_busy", 32'(if0.load_busy), 1);
    chk("restart_done", 32'(if0.load_done), 0);
    send(32'hB000_0002);
    chk("b_done", 32'(if0.load_done), 1);
    step();
    fetch(10);
    chk("f10", if0.instr_out, 32'hB000_0000);
    fetch(11);
    chk("f11", if0.instr_out, 32'hB000_0001);
    fetch(12);
    chk("f12", if0.instr_out, 32'hB000_0002);
    fetch(50);
    chk("f50", if0.instr_out, 32'h0);
    fetch_en = 1'b0;

    start_load(5, 0);
    chk("z_done", 32'(if0.load_done), 1);
    chk("z_ready", 32'(if0.load_ready), 0);
    step();
    chk("z_idle", 32'(if0.load_busy), 0);

    start_load(0, 5);
    send(32'hC000_0000);
    send(32'hC000_0001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r_busy", 32'(if0.load_busy), 0);
    chk("r_done", 32'(if0.load_done), 0);
    step();
    chk("r_done2", 32'(if0.load_done), 0);
    fetch(0);
    chk("r_f0", if0.instr_out, 32'hC000_0000);
    fetch(1);
    chk("r_f1", if0.instr_out, 32'hC000_0001);
    fetch(2);
    chk("r_f2", if0.instr_out, 32'h00800008);
    fetch_en = 1'b0;
    step();
    chk("done_pulses", 32'(done_cnt), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_instr_mem.md
Name: prog_instr_mem

Overview:
- Parametrised, loadable instruction memory for the single-cycle computer. It replaces the fixed-content, combinational ROM.
- Fetch is registered, with one-cycle latency, and has range and alignment checking.
- A streaming load port with a valid/ready handshake writes a program image at run time. A loader FSM sequences the writes.
- Sits between the PC register and the instruction decoder; the load port is driven by a test bench or boot controller.

Parameters:
- DATA_W, 32, instruction word width.
- ADDR_W, 32, fetch/load address width.
- DEPTH, 128, number of instruction words.
- BYTE_ADDR, 0. 0 = word address (index = addr). 1 = byte address (index = addr >> 2, addr[1:0] must be 0).
- NOP_WORD, 32'h00000000, word returned on fault, during load, and after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fetch_en  in  1  fetch request this cycle.
- fetch_addr  in  ADDR_W  fetch address (PC).
- instr_out  out  DATA_W  fetched instruction (registered).
- instr_valid  out  1  instr_out holds the result of an accepted fetch.
- fetch_fault  out  1  previous fetch was out of range or misaligned.
- load_start  in  1  begin a load of load_len words at load_base.
- load_base  in  ADDR_W  first word index of the load (always a word index, independent of BYTE_ADDR).
- load_len  in  LEN_W=$clog2(DEPTH+1)  number of words to load.
- load_valid  in  1  load_data is valid.
- load_data  in  DATA_W  program word.
- load_ready  out  1  block accepts load_data this cycle.
- load_busy  out  1  loader FSM is not in IDLE.
- load_done  out  1  one-cycle pulse when the load completes.
- load_error  out  1  sticky: at least one load write fell outside DEPTH.

Behaviour:
- Reset values: instr_out=NOP_WORD, instr_valid=0, fetch_fault=0, load_ready=0, load_busy=0, load_done=0, load_error=0, FSM=IDLE, word counter=0.
- Reset does not clear memory contents. Simulation initialises all words to NOP_WORD.
- Fetch, when fetch_en=1 and FSM=IDLE, updates outputs on the next edge:
  - In range and aligned: instr_out=mem[idx], instr_valid=1, fetch_fault=0.
  - idx >= DEPTH, or BYTE_ADDR=1 with addr[1:0]!=0: instr_out=NOP_WORD, instr_valid=1, fetch_fault=1.
- fetch_en=0 in IDLE: instr_valid=0; instr_out and fetch_fault hold their values.
- Fetch while load_busy=1: request ignored; next cycle instr_out=NOP_WORD, instr_valid=0, fetch_fault=0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE -> LOAD: on load_start with load_len != 0. Capture base and len, clear counter, clear load_error.
  - IDLE -> DONE: on load_start with load_len == 0. No writes are performed.
  - LOAD: load_ready=1. On each load_valid & load_ready, write mem[base+cnt] = load_data and increment cnt.
    - If base+cnt >= DEPTH, drop the write, set load_error, and still count the word.
    - Compute base+cnt at ADDR_W+1 bits so that no wrap-around occurs.
    - When the word at cnt = len-1 is accepted, go to DONE.
  - DONE: load_done=1 for exactly one cycle, load_ready=0, then IDLE.
- load_start outside IDLE is ignored.
- load_valid outside LOAD is ignored; no write occurs.
- Memory writes are synchronous.
- A fetch issued in the first IDLE cycle after DONE sees all loaded words.
- Reset during LOAD: FSM returns to IDLE. Words already written stay; unwritten words keep their old values. load_done does not pulse.
- Simultaneous reset and load_start: reset wins.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/LOAD/DONE);
  - the NOP_WORD default;
  - the index-width function ($clog2(DEPTH)).
- One sub-module, imem_loader_fsm, contains the state machine, counter, address generation and error flag. It drives a write-enable/index/data triple into the storage array in prog_instr_mem.

Test Plan:
- Reset, then fetch_en=1 with fetch_addr=0 → one cycle later instr_out=32'h00000000, instr_valid=1, fetch_fault=0. Check all load outputs are 0.
- Load base=0, len=3 with words 32'h04100000, 32'h04181002, 32'h00800008; insert a one-cycle load_valid gap → load_done pulses once after the third accept. Fetches of 0, 1 and 2 return the three words with one-cycle latency.
- Load base=126, len=4 with DEPTH=128 → words written at 126 and 127 only, load_error=1, load_done pulses after the 4th accept. A fetch at 128 gives NOP_WORD with fetch_fault=1.
- BYTE_ADDR=1: fetch 32'h8 → mem[2]. Fetch 32'h6 → NOP_WORD, fetch_fault=1.
- Assert fetch_en during LOAD → instr_valid=0, instr_out=NOP_WORD. Assert load_start mid-load → ignored; the original len is honoured.
- Reset after 2 of 5 words → FSM IDLE, no load_done. Words 0 and 1 hold the new data; word 2 holds its old value.
